// File: rtl/lcd_arbiter_pkg.sv
// Shared state encodings and default sizing for the LCD arbiter.
package lcd_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } lcdarb_state_e;

  localparam int LCDARB_NREQ_DEF  = 4;
  localparam int LCDARB_DIGIT_DEF = 8;
endpackage

// File: rtl/lcdarb_rr.sv
// Combinational round-robin picker: first pending requester at or after i_ptr, modulo NREQ.
module lcdarb_rr #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_vld,
  output logic [PW-1:0]   o_idx,
  output logic [NREQ-1:0] o_oh
);
  logic [PW-1:0] w_c;

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_c = PW'((int'(i_ptr) + i) % NREQ);
      if (!o_vld && i_pend[w_c]) begin
        o_vld = 1'b1;
        o_idx = w_c;
      end
    end
    o_oh = o_vld ? (NREQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one LCD serial controller among NREQ posted-write requesters.
// Optional LCDARB_COALESCE_EN: a write to an already-pending requester overwrites instead of dropping.
module lcd_arbiter
  import lcd_arbiter_pkg::*;
#(
  parameter int NREQ  = LCDARB_NREQ_DEF,
  parameter int DIGIT = LCDARB_DIGIT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic [NREQ*DIGIT*4-1:0] REQ_DATA,
  input  logic [NREQ-1:0]         REQ_WE,
  output logic [NREQ-1:0]         REQ_PEND,
  output logic [NREQ-1:0]         REQ_DROP,
  output logic [NREQ-1:0]         GRANT,
  output logic [DIGIT*4-1:0]      LCD_DATA,
  output logic                    LCD_WE,
  input  logic                    LCD_READY
);
  localparam int DW = DIGIT * 4;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lcdarb_state_e r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_drop;
  logic [NREQ-1:0] r_grant;
  logic [DW-1:0]   r_lcd_data;
  logic            r_lcd_we;
  logic [DW-1:0]   r_buf [NREQ];

  logic            w_vld;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_oh;
  logic            w_issue;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_load;
  logic [NREQ-1:0] w_drop;
  logic [PW-1:0]   w_ptr_nxt;

  lcdarb_rr #(.NREQ(NREQ), .PW(PW)) u_rr (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_vld  (w_vld),
    .o_idx  (w_idx),
    .o_oh   (w_oh)
  );

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

  // A write landing on the grant edge is accepted: set wins over clear.
  always_comb begin
    w_issue = (r_state == IDLE) && w_vld && LCD_READY;
    w_clr   = w_issue ? w_oh : '0;
`ifdef LCDARB_COALESCE_EN
    w_load  = REQ_WE;
    w_drop  = '0;
`else
    w_load  = REQ_WE & (~r_pend | w_clr);
    w_drop  = REQ_WE & r_pend & ~w_clr;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_issue)    w_state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!LCD_READY) w_state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (LCD_READY)  w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_grant    <= '0;
      r_lcd_data <= '0;
      r_lcd_we   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= (r_pend & ~w_clr) | w_load;
      r_drop   <= w_drop;
      r_lcd_we <= w_issue;
      if (w_issue) begin
        r_lcd_data <= r_buf[w_idx];
        r_grant    <= w_oh;
        r_ptr      <= w_ptr_nxt;
      end else if ((r_state == WAIT_HIGH) && LCD_READY) begin
        r_grant <= '0;
      end
    end
  end

  // Buffer contents are only meaningful while the matching pending bit is set.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < NREQ; r++) begin
      if (w_load[r]) r_buf[r] <= REQ_DATA[r*DW +: DW];
    end
  end

  assign REQ_PEND = r_pend;
  assign REQ_DROP = r_drop;
  assign GRANT    = r_grant;
  assign LCD_DATA = r_lcd_data;
  assign LCD_WE   = r_lcd_we;
endmodule
